row_filter_sched: RTL and testbench

//  Sequencer for a single shared 3-tap row_filter datapath. Computes one 3x3 convolution

---
 rtl/row_filter_sched_pkg.sv | 35 +++
 rtl/row_filter_sched_if.sv | 34 +++
 rtl/row_filter_sched_wbank.sv | 45 ++++
 rtl/row_filter_sched.sv | 157 +++++++++++++++
 tb/tb_row_filter_sched.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/row_filter_sched_pkg.sv
// Shared types and constants for the row_filter_sched block: FSM encoding,
// kernel geometry, accumulator width and a constant clog2 helper.
package row_filter_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int         KERNEL_TAPS = 9;
  localparam int         KERNEL_ROWS = 3;
  localparam int         KERNEL_COLS = 3;
  localparam int         KIDX_W      = 4;
  localparam logic [1:0] ROW_LAST    = 2'(KERNEL_ROWS - 1);

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  // Three row sums of 2*BW-bit products need two guard bits.
  function automatic int acc_w(input int bitwidth);
    return 2 * bitwidth + 2;
  endfunction

endpackage

// File: rtl/row_filter_sched_if.sv
// Bus between the scheduler (master) and the shared 3-tap row filter (slave).
interface row_filter_sched_if
  import row_filter_sched_pkg::*;
#(
  parameter int BITWIDTH = 8
) ();

  localparam int LC_W = clog2(BITWIDTH) + 2;

  logic                  rf_data_in_valid;
  logic [BITWIDTH-1:0]   rf_din1;
  logic [BITWIDTH-1:0]   rf_din2;
  logic [BITWIDTH-1:0]   rf_din3;
  logic [BITWIDTH-1:0]   rf_weight1;
  logic [BITWIDTH-1:0]   rf_weight2;
  logic [BITWIDTH-1:0]   rf_weight3;
  logic                  rf_metronome;
  logic [LC_W-1:0]       rf_last_count;
  logic                  rf_data_out_valid;
  logic [2*BITWIDTH-1:0] rf_dout;

  modport master (
    output rf_data_in_valid, rf_din1, rf_din2, rf_din3,
           rf_weight1, rf_weight2, rf_weight3, rf_metronome, rf_last_count,
    input  rf_data_out_valid, rf_dout
  );

  modport slave (
    input  rf_data_in_valid, rf_din1, rf_din2, rf_din3,
           rf_weight1, rf_weight2, rf_weight3, rf_metronome, rf_last_count,
    output rf_data_out_valid, rf_dout
  );

endinterface

// File: rtl/row_filter_sched_wbank.sv
// 9-entry 3x3 kernel weight register file with a kernel-row read mux.
// Writes to indices 9..15 are dropped.
module row_filter_sched_wbank
  import row_filter_sched_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [KIDX_W-1:0]   addr,
  input  logic [BITWIDTH-1:0] wdata,
  input  logic [1:0]          row,
  output logic [BITWIDTH-1:0] row_w [KERNEL_COLS]
);

  logic [BITWIDTH-1:0] w_q [KERNEL_TAPS];
  logic [BITWIDTH-1:0] w_d [KERNEL_TAPS];
  logic [KIDX_W-1:0]   base;

  always_comb begin
    w_d = w_q;
    if (we && (addr < KIDX_W'(KERNEL_TAPS))) begin
      w_d[addr] = wdata;
    end
  end

  always_comb begin
    base = KIDX_W'(row) * KIDX_W'(KERNEL_COLS);
    for (int j = 0; j < KERNEL_COLS; j++) begin
      row_w[j] = w_q[base + KIDX_W'(j)];
    end
  end

  // NOTE: the weight bank is reset explicitly; a reset must never leave stale
  // kernel weights behind, unlike a plain data RAM that can stay unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '{default: '0};
    end else begin
      w_q <= w_d;
    end
  end

endmodule

// File: rtl/row_filter_sched.sv
// Sequencer time-multiplexing one shared 3-tap row filter over the three kernel
// rows of a 3x3 window. Optional ReLU on the result: ROW_FILTER_SCHED_RELU_EN.
module row_filter_sched
  import row_filter_sched_pkg::*;
#(
  parameter int BITWIDTH   = 8,
  parameter int MUL_CYCLES = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  input  logic [3:0]              w_addr,
  input  logic [BITWIDTH-1:0]     w_data,
  input  logic                    win_valid,
  output logic                    win_ready,
  input  logic [9*BITWIDTH-1:0]   win_pix,
  row_filter_sched_if.master      rf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*BITWIDTH+1:0]   out_data,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int ACC_W = acc_w(BITWIDTH);
  localparam int LC_W  = clog2(BITWIDTH) + 2;
  localparam int TMO_W = clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [1:0]          row_q, row_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic [BITWIDTH-1:0] pix_q [KERNEL_TAPS];
  logic [BITWIDTH-1:0] pix_d [KERNEL_TAPS];

  logic                w_we;
  logic [BITWIDTH-1:0] row_w [KERNEL_COLS];
  logic [KIDX_W-1:0]   base;
  logic                active;
  logic [ACC_W-1:0]    dout_ext;

  row_filter_sched_wbank #(.BITWIDTH(BITWIDTH)) u_wbank (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .addr  (w_addr),
    .wdata (w_data),
    .row   (row_q),
    .row_w (row_w)
  );

  // Weight writes win over a window in the same IDLE cycle.
  assign w_we      = (state_q == ST_IDLE) && w_valid;
  assign win_ready = (state_q == ST_IDLE) && !w_valid && !rst;
  assign dout_ext  = {{(ACC_W - 2*BITWIDTH){rf.rf_dout[2*BITWIDTH-1]}}, rf.rf_dout};

  // NOTE: every _d gets its default first, so no branch leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    acc_d   = acc_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    pix_d   = pix_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid && win_ready) begin
          for (int k = 0; k < KERNEL_TAPS; k++) begin
            pix_d[k] = win_pix[k*BITWIDTH +: BITWIDTH];
          end
          row_d   = '0;
          acc_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rf.rf_data_out_valid) begin
          acc_d = acc_q + dout_ext;
          if (row_q == ROW_LAST) begin
            state_d = ST_OUT;
          end else begin
            row_d   = row_q + 2'd1;
            state_d = ST_ISSUE;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          acc_d   = '0;
          row_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          row_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Row operands are forced to zero outside ISSUE/WAIT so idle outputs stay quiet.
  always_comb begin
    base                = KIDX_W'(row_q) * KIDX_W'(KERNEL_COLS);
    active              = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    rf.rf_data_in_valid = (state_q == ST_ISSUE);
    rf.rf_metronome     = (state_q == ST_WAIT);
    rf.rf_last_count    = LC_W'(MUL_CYCLES - 1);
    rf.rf_din1          = active ? pix_q[base]             : '0;
    rf.rf_din2          = active ? pix_q[base + KIDX_W'(1)] : '0;
    rf.rf_din3          = active ? pix_q[base + KIDX_W'(2)] : '0;
    rf.rf_weight1       = active ? row_w[0] : '0;
    rf.rf_weight2       = active ? row_w[1] : '0;
    rf.rf_weight3       = active ? row_w[2] : '0;
  end

  assign out_valid   = (state_q == ST_OUT);
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;

`ifdef ROW_FILTER_SCHED_RELU_EN
  assign out_data = (out_valid && !acc_q[ACC_W-1]) ? acc_q : '0;
`else
  assign out_data = out_valid ? acc_q : '0;
`endif

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      acc_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      pix_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      pix_q   <= pix_d;
    end
  end

endmodule

// File: tb/tb_row_filter_sched.sv
// Self-checking bench for row_filter_sched with a behavioural row filter and a
// 3x3 dot-product reference model; honours ROW_FILTER_SCHED_RELU_EN.
module tb_row_filter_sched;
  import row_filter_sched_pkg::*;

  localparam int BW      = 8;
  localparam int MC      = 8;
  localparam int TO      = 64;
  localparam int LATENCY = 3 * (1 + MC) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              w_valid = 1'b0;
  logic [3:0]        w_addr = '0;
  logic [BW-1:0]     w_data = '0;
  logic              win_valid = 1'b0;
  logic              win_ready;
  logic [9*BW-1:0]   win_pix = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2*BW+1:0]   out_data;
  logic              busy;
  logic              err_timeout;

  row_filter_sched_if #(.BITWIDTH(BW)) rf_bus ();

  row_filter_sched #(.BITWIDTH(BW), .MUL_CYCLES(MC), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .w_valid     (w_valid),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_pix     (win_pix),
    .rf          (rf_bus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wts [9];
  int pix [9];

  // Behavioural row filter: returns the 3-tap dot product MC cycles after a start.
  bit            model_en = 1'b1;
  int            mcnt = 0;
  logic [2*BW-1:0] mres = '0;

  function automatic int row_prod();
    return int'($signed(rf_bus.rf_din1)) * int'($signed(rf_bus.rf_weight1)) +
           int'($signed(rf_bus.rf_din2)) * int'($signed(rf_bus.rf_weight2)) +
           int'($signed(rf_bus.rf_din3)) * int'($signed(rf_bus.rf_weight3));
  endfunction

  always @(posedge clk) begin
    if (rst || !model_en) begin
      mcnt <= 0;
    end else if (rf_bus.rf_data_in_valid) begin
      mcnt <= MC;
      mres <= (2*BW)'(row_prod());
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign rf_bus.rf_data_out_valid = (mcnt == 1);
  assign rf_bus.rf_dout           = mres;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int ref_sum();
    int s;
    s = 0;
    for (int k = 0; k < 9; k++) s += wts[k] * pix[k];
`ifdef ROW_FILTER_SCHED_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic load_weights();
    for (int k = 0; k < 9; k++) begin
      w_valid = 1'b1;
      w_addr  = 4'(k);
      w_data  = BW'(wts[k]);
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
  endtask

  task automatic run_window(input string tag, input int hold, input bit poke);
    int lat;
    int expv;
    expv = ref_sum();
    for (int k = 0; k < 9; k++) win_pix[k*BW +: BW] = BW'(pix[k]);
    win_valid = 1'b1;
    #1;
    check({tag, " win_ready"}, win_ready, 1);
    @(posedge clk); #1;
    win_valid = 1'b0;
    win_pix   = (9*BW)'({$urandom(), $urandom(), $urandom()});
    lat = 1;
    while (out_valid !== 1'b1 && lat < 4 * LATENCY) begin
      if (poke) begin
        w_valid = (lat == 3);
        w_addr  = 4'd0;
        w_data  = 8'd99;
      end
      @(posedge clk); #1;
      lat++;
    end
    w_valid = 1'b0;
    check({tag, " latency"}, lat, LATENCY);
    check({tag, " out_data"}, $signed(out_data), expv);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, out_valid, 1);
      check({tag, " hold data"}, $signed(out_data), expv);
      check({tag, " hold win_ready"}, win_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " released"}, {out_valid, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int pulses;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst win_ready", win_ready, 0);
    check("rst busy", busy, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", $signed(out_data), 0);
    check("rst err", err_timeout, 0);
    check("rst rf start", rf_bus.rf_data_in_valid, 0);
    check("rst metronome", rf_bus.rf_metronome, 0);
    check("last_count", rf_bus.rf_last_count, MC - 1);
    rst = 1'b0;
    #1;
    check("idle win_ready", win_ready, 1);
    @(posedge clk); #1;

    // Test 1 + 4: unit weights, pixels 1..9, result held 10 cycles
    for (int k = 0; k < 9; k++) begin wts[k] = 1; pix[k] = k + 1; end
    load_weights();
    run_window("t1", 10, 1'b0);

    // Test 2: weights -1, pixels 127
    for (int k = 0; k < 9; k++) begin wts[k] = -1; pix[k] = 127; end
    load_weights();
    run_window("t2", 0, 1'b0);

    // Test 3: large-magnitude rows, sum beyond the row-result width
    for (int k = 0; k < 9; k++) begin wts[k] = -128; pix[k] = -85; end
    load_weights();
    run_window("t3 pos", 1, 1'b0);
    for (int k = 0; k < 9; k++) begin wts[k] = 127; pix[k] = -86; end
    load_weights();
    run_window("t3 neg", 1, 1'b0);

    // Weight write has priority over a window; out-of-range indices ignored
    win_valid = 1'b1;
    w_valid   = 1'b1;
    w_addr    = 4'd4;
    w_data    = 8'd5;
    #1;
    check("prio win_ready", win_ready, 0);
    @(posedge clk); #1;
    win_valid = 1'b0;
    w_valid   = 1'b0;
    check("prio not accepted", busy, 0);
    wts[4] = 5;
    for (int a = 9; a < 16; a++) begin
      w_valid = 1'b1;
      w_addr  = 4'(a);
      w_data  = 8'd77;
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    for (int k = 0; k < 9; k++) pix[k] = k - 4;
    run_window("prio", 0, 1'b1);

    // Randomised windows (values bounded so every row fits the row-result width)
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 9; k++) begin
        wts[k] = int'($urandom_range(127, 0)) - 64;
        pix[k] = int'($urandom_range(127, 0)) - 64;
      end
      load_weights();
      run_window("rand", int'($urandom_range(3, 0)), n == 0);
    end

    // Test 5: row filter never answers
    model_en = 1'b0;
    win_pix   = (9*BW)'({$urandom(), $urandom(), $urandom()});
    win_valid = 1'b1;
    @(posedge clk); #1;
    win_valid = 1'b0;
    t = 0;
    while (rf_bus.rf_metronome !== 1'b1 && t < 10) begin @(posedge clk); #1; t++; end
    check("tmo wait entered", rf_bus.rf_metronome, 1);
    t = 0;
    while (err_timeout !== 1'b1 && t < 4 * TO) begin @(posedge clk); #1; t++; end
    check("tmo cycles", t, TO);
    check("tmo idle", {busy, out_valid, rf_bus.rf_metronome}, 0);
    model_en = 1'b1;
    for (int k = 0; k < 9; k++) pix[k] = 2 * k - 7;
    run_window("post tmo", 0, 1'b0);
    check("tmo sticky", err_timeout, 1);

    // Test 6: reset during WAIT of kernel row 1
    for (int k = 0; k < 9; k++) pix[k] = k + 10;
    for (int k = 0; k < 9; k++) win_pix[k*BW +: BW] = BW'(pix[k]);
    win_valid = 1'b1;
    @(posedge clk); #1;
    win_valid = 1'b0;
    pulses = 0;
    t = 0;
    while (pulses < 2 && t < 100) begin
      if (rf_bus.rf_data_in_valid === 1'b1) pulses++;
      @(posedge clk); #1;
      t++;
    end
    check("mid wait row1", rf_bus.rf_metronome, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid rst ctl", {busy, out_valid, rf_bus.rf_data_in_valid, rf_bus.rf_metronome,
                          err_timeout, win_ready}, 0);
    check("mid rst data", {out_data, rf_bus.rf_din1, rf_bus.rf_weight1}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) wts[k] = 0;
    run_window("cleared wts", 0, 1'b0);
    for (int k = 0; k < 9; k++) wts[k] = 9 - 2 * k;
    load_weights();
    run_window("after rst", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
